serial_subtractor: RTL

- Bit-serial two's-complement subtractor: computes a - b one bit per clock, LSB first, through a single full-subtractor cell and a borrow flop.
- It is the inverse-direction companion to the ripple-carry adder family.
- It trades latency for area in datapaths where one subtract per WIDTH cycles is enough.
- Start/busy/done handshake, so a controlling FSM can sequence it.

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor. It computes a - b one bit per
//   clock, LSB first, using one full-subtractor cell and a borrow flop.
//   A start/busy/done handshake lets a controlling FSM sequence it.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request; sampled only while busy=0
//   a, b   minuend / subtrahend, captured on the accepted start edge
//   busy   high while a subtraction is in progress
//   done   one-cycle pulse: diff/bout/ovf are newly valid
//   diff   a - b modulo 2^WIDTH (holds until the next completed operation)
//   bout   final borrow out; 1 iff a < b as unsigned
//   ovf    signed overflow of a - b
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic             d;
    logic             borrow_next;
    logic [WIDTH-1:0] res_next;
    logic             last;

    // Full-subtractor cell on the current LSBs; the difference bit enters
    // the result register from the MSB end so that after WIDTH shifts the
    // first (LSB) bit has reached bit 0.
    always_comb begin
        d           = sa[0] ^ sb[0] ^ borrow;
        borrow_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
        res_next    = {d, res[WIDTH-1:1]};
        last        = (cnt == CW'(WIDTH - 1));
    end

    assign busy = (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        res    <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    res    <= res_next;
                    borrow <= borrow_next;
                    if (last) begin
                        // Counter returns to zero rather than reaching WIDTH.
                        cnt   <= '0;
                        diff  <= res_next;
                        bout  <= borrow_next;
                        // d is the MSB of the finished difference.
                        ovf   <= (a_msb != b_msb) && (d != a_msb);
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
